// File: rtl/regfile_pkg.sv
// Shared constants and write-port priority helper for the multi-port register file.
package regfile_pkg;

    localparam int DATA_WIDTH_DEF  = 32;
    localparam int REG_COUNT_DEF   = 32;
    localparam int MAX_WRITE_PORTS = 4;

    // Returns the index of the highest set bit; callers gate on |match.
    function automatic int highest_match(input logic [MAX_WRITE_PORTS-1:0] match);
        int idx;
        idx = 0;
        for (int w = 0; w < MAX_WRITE_PORTS; w++) begin
            if (match[w]) idx = w;
        end
        return idx;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Issue-time busy bits: reserve sets, writeback clears, reserve beats writeback.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int REG_COUNT   = REG_COUNT_DEF,
    parameter int ADDR_WIDTH  = $clog2(REG_COUNT),
    parameter int READ_PORTS  = 2,
    parameter int WRITE_PORTS = 2,
    parameter bit ZERO_REG    = 1'b1
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic [WRITE_PORTS-1:0]            rsv_en_i,
    input  logic [WRITE_PORTS*ADDR_WIDTH-1:0] rsv_addr_i,
    input  logic [WRITE_PORTS-1:0]            wb_en_i,
    input  logic [WRITE_PORTS*ADDR_WIDTH-1:0] wb_addr_i,
    input  logic [READ_PORTS*ADDR_WIDTH-1:0]  rd_addr_i,
    output logic [READ_PORTS-1:0]             rd_busy_o,
    output logic                              any_busy_o
);

    logic [REG_COUNT-1:0] busy_q;
    logic [REG_COUNT-1:0] busy_d;

    // Clears are applied first so a same-cycle reserve of the newer producer wins.
    always_comb begin
        busy_d = busy_q;
        for (int w = 0; w < WRITE_PORTS; w++) begin
            if (wb_en_i[w]) busy_d[wb_addr_i[w*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b0;
        end
        for (int s = 0; s < WRITE_PORTS; s++) begin
            if (rsv_en_i[s]) busy_d[rsv_addr_i[s*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b1;
        end
        if (ZERO_REG) busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            busy_q     <= '0;
            any_busy_o <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            any_busy_o <= |busy_d;
        end
    end

    always_comb begin
        for (int r = 0; r < READ_PORTS; r++) begin
            rd_busy_o[r] = busy_q[rd_addr_i[r*ADDR_WIDTH +: ADDR_WIDTH]];
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port GPR file with optional zero register, write-to-read bypass and busy scoreboard.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int REG_COUNT   = REG_COUNT_DEF,
    parameter int ADDR_WIDTH  = $clog2(REG_COUNT),
    parameter int READ_PORTS  = 2,
    parameter int WRITE_PORTS = 2,
    parameter bit ZERO_REG    = 1'b1,
    parameter bit BYPASS      = 1'b1
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic [READ_PORTS*ADDR_WIDTH-1:0]  rd_addr_i,
    output logic [READ_PORTS*DATA_WIDTH-1:0]  rd_data_o,
    output logic [READ_PORTS-1:0]             rd_busy_o,
    input  logic [WRITE_PORTS-1:0]            wr_en_i,
    input  logic [WRITE_PORTS*ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [WRITE_PORTS*DATA_WIDTH-1:0] wr_data_i,
    input  logic [WRITE_PORTS-1:0]            rsv_en_i,
    input  logic [WRITE_PORTS*ADDR_WIDTH-1:0] rsv_addr_i,
    output logic                              any_busy_o
);

    logic [DATA_WIDTH-1:0]      regs_q      [REG_COUNT];
    logic [WRITE_PORTS-1:0]     wr_eff;
    logic [MAX_WRITE_PORTS-1:0] wr_hit      [REG_COUNT];
    logic [DATA_WIDTH-1:0]      wr_sel_data [REG_COUNT];
    logic [ADDR_WIDTH-1:0]      rd_addr     [READ_PORTS];
    logic [READ_PORTS-1:0]      sb_busy;

    always_comb begin
        for (int w = 0; w < WRITE_PORTS; w++) begin
            wr_eff[w] = wr_en_i[w] &&
                        !(ZERO_REG && (wr_addr_i[w*ADDR_WIDTH +: ADDR_WIDTH] == '0));
        end
    end

    // Per-register winning write data, shared by the register update and the bypass path.
    always_comb begin
        for (int i = 0; i < REG_COUNT; i++) begin
            wr_hit[i]      = '0;
            wr_sel_data[i] = '0;
            for (int w = 0; w < WRITE_PORTS; w++) begin
                wr_hit[i][w] = wr_eff[w] &&
                               (wr_addr_i[w*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(i));
            end
            for (int w = 0; w < WRITE_PORTS; w++) begin
                if (w == highest_match(wr_hit[i]))
                    wr_sel_data[i] = wr_data_i[w*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
        end else begin
            for (int i = 0; i < REG_COUNT; i++) begin
                if (|wr_hit[i]) regs_q[i] <= wr_sel_data[i];
            end
        end
    end

    always_comb begin
        for (int r = 0; r < READ_PORTS; r++) begin
            rd_addr[r] = rd_addr_i[r*ADDR_WIDTH +: ADDR_WIDTH];
        end
    end

    regfile_scoreboard #(
        .REG_COUNT   (REG_COUNT),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .READ_PORTS  (READ_PORTS),
        .WRITE_PORTS (WRITE_PORTS),
        .ZERO_REG    (ZERO_REG)
    ) u_scoreboard (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .rsv_en_i   (rsv_en_i),
        .rsv_addr_i (rsv_addr_i),
        .wb_en_i    (wr_en_i),
        .wb_addr_i  (wr_addr_i),
        .rd_addr_i  (rd_addr_i),
        .rd_busy_o  (sb_busy),
        .any_busy_o (any_busy_o)
    );

    // A forwarded write hides the busy bit since the consumer already gets the data.
    always_comb begin
        rd_data_o = '0;
        rd_busy_o = '0;
        for (int r = 0; r < READ_PORTS; r++) begin
            rd_data_o[r*DATA_WIDTH +: DATA_WIDTH] = regs_q[rd_addr[r]];
            if (BYPASS && (|wr_hit[rd_addr[r]]))
                rd_data_o[r*DATA_WIDTH +: DATA_WIDTH] = wr_sel_data[rd_addr[r]];
            if (ZERO_REG && (rd_addr[r] == '0))
                rd_data_o[r*DATA_WIDTH +: DATA_WIDTH] = '0;
            rd_busy_o[r] = sb_busy[r] && !(BYPASS && (|wr_hit[rd_addr[r]]));
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench: bypass and non-bypass instances share stimulus and a rule-level model.
module tb_regfile_mp;

    localparam int DW = 32;
    localparam int RC = 32;
    localparam int AW = 5;
    localparam int RP = 2;
    localparam int WP = 2;

    logic          clk;
    logic          rst_n;
    logic [RP*AW-1:0] rd_addr;
    logic [RP*DW-1:0] rd_data_bp;
    logic [RP*DW-1:0] rd_data_nb;
    logic [RP-1:0]    rd_busy_bp;
    logic [RP-1:0]    rd_busy_nb;
    logic [WP-1:0]    wr_en;
    logic [WP*AW-1:0] wr_addr;
    logic [WP*DW-1:0] wr_data;
    logic [WP-1:0]    rsv_en;
    logic [WP*AW-1:0] rsv_addr;
    logic             any_busy_bp;
    logic             any_busy_nb;

    int compared   = 0;
    int mismatched = 0;

    logic [DW-1:0] m_regs [RC];
    logic [RC-1:0] m_busy;
    logic [RC-1:0] m_busy_next;
    logic          m_any;

    regfile_mp #(.BYPASS(1'b1)) dut (
        .clk_i      (clk),
        .reset_i    (rst_n),
        .rd_addr_i  (rd_addr),
        .rd_data_o  (rd_data_bp),
        .rd_busy_o  (rd_busy_bp),
        .wr_en_i    (wr_en),
        .wr_addr_i  (wr_addr),
        .wr_data_i  (wr_data),
        .rsv_en_i   (rsv_en),
        .rsv_addr_i (rsv_addr),
        .any_busy_o (any_busy_bp)
    );

    regfile_mp #(.BYPASS(1'b0)) dut_nb (
        .clk_i      (clk),
        .reset_i    (rst_n),
        .rd_addr_i  (rd_addr),
        .rd_data_o  (rd_data_nb),
        .rd_busy_o  (rd_busy_nb),
        .wr_en_i    (wr_en),
        .wr_addr_i  (wr_addr),
        .wr_data_i  (wr_data),
        .rsv_en_i   (rsv_en),
        .rsv_addr_i (rsv_addr),
        .any_busy_o (any_busy_nb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [AW-1:0] wa(input int w);
        return wr_addr[w*AW +: AW];
    endfunction

    function automatic logic [DW-1:0] wd(input int w);
        return wr_data[w*DW +: DW];
    endfunction

    function automatic logic [AW-1:0] sa(input int s);
        return rsv_addr[s*AW +: AW];
    endfunction

    function automatic logic [AW-1:0] ra(input int r);
        return rd_addr[r*AW +: AW];
    endfunction

    // Model state: ports applied in ascending order so the highest index lands last.
    initial begin
        for (int i = 0; i < RC; i++) m_regs[i] = '0;
        m_busy = '0;
        m_any  = 1'b0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int i = 0; i < RC; i++) m_regs[i] = '0;
                m_busy = '0;
                m_any  = 1'b0;
            end else begin
                for (int w = 0; w < WP; w++) begin
                    if (wr_en[w] && wa(w) != 0) m_regs[wa(w)] = wd(w);
                end
                m_busy_next = m_busy;
                for (int w = 0; w < WP; w++) begin
                    if (wr_en[w]) m_busy_next[wa(w)] = 1'b0;
                end
                for (int s = 0; s < WP; s++) begin
                    if (rsv_en[s] && sa(s) != 0) m_busy_next[sa(s)] = 1'b1;
                end
                m_busy = m_busy_next;
                m_any  = |m_busy_next;
            end
        end
    end

    function automatic logic [DW-1:0] exp_data(input int r, input bit byp);
        logic [AW-1:0] a;
        logic [DW-1:0] v;
        a = ra(r);
        if (a == 0) return '0;
        v = m_regs[a];
        if (byp) begin
            for (int w = 0; w < WP; w++) begin
                if (wr_en[w] && wa(w) == a) v = wd(w);
            end
        end
        return v;
    endfunction

    function automatic logic exp_busy(input int r, input bit byp);
        logic [AW-1:0] a;
        a = ra(r);
        if (byp && a != 0) begin
            for (int w = 0; w < WP; w++) begin
                if (wr_en[w] && wa(w) == a) return 1'b0;
            end
        end
        return m_busy[a];
    endfunction

    task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Every falling edge: both instances against the model.
    initial begin
        forever begin
            @(negedge clk);
            for (int r = 0; r < RP; r++) begin
                checkOutput($sformatf("model rd_data_bp[%0d]", r), rd_data_bp[r*DW +: DW], exp_data(r, 1'b1));
                checkOutput($sformatf("model rd_data_nb[%0d]", r), rd_data_nb[r*DW +: DW], exp_data(r, 1'b0));
                checkOutput($sformatf("model rd_busy_bp[%0d]", r), {31'b0, rd_busy_bp[r]}, {31'b0, exp_busy(r, 1'b1)});
                checkOutput($sformatf("model rd_busy_nb[%0d]", r), {31'b0, rd_busy_nb[r]}, {31'b0, exp_busy(r, 1'b0)});
            end
            checkOutput("model any_busy_bp", {31'b0, any_busy_bp}, {31'b0, m_any});
            checkOutput("model any_busy_nb", {31'b0, any_busy_nb}, {31'b0, m_any});
        end
    end

    task automatic applyStimulus(input logic [WP-1:0] we, input logic [AW-1:0] wa0, input logic [AW-1:0] wa1,
                                 input logic [DW-1:0] wd0, input logic [DW-1:0] wd1,
                                 input logic [WP-1:0] re, input logic [AW-1:0] rs0, input logic [AW-1:0] rs1,
                                 input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
        wr_en    = we;
        wr_addr  = {wa1, wa0};
        wr_data  = {wd1, wd0};
        rsv_en   = re;
        rsv_addr = {rs1, rs0};
        rd_addr  = {ra1, ra0};
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 3) != 0) return AW'($urandom_range(0, 7));
        return AW'($urandom_range(0, RC - 1));
    endfunction

    initial begin
        rst_n = 1'b0;
        applyStimulus(2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        settle();
        checkOutput("reset rd_data", rd_data_bp[DW-1:0], 32'h0000_0000);
        checkOutput("reset rd_busy", {30'b0, rd_busy_bp}, 32'h0);
        checkOutput("reset any_busy", {31'b0, any_busy_bp}, 32'h0);
        nextCycle();
        rst_n = 1'b1;

        // Commit a value, then assert reset in the middle of a write+reserve cycle.
        applyStimulus(2'b01, 5, 0, 32'h1234_5678, 0, 2'b00, 0, 0, 5, 5);
        settle();
        checkOutput("bypass first write", rd_data_bp[DW-1:0], 32'h1234_5678);
        checkOutput("no bypass first write", rd_data_nb[DW-1:0], 32'h0000_0000);
        nextCycle();
        applyStimulus(2'b01, 5, 0, 32'hDEAD_BEEF, 0, 2'b01, 5, 0, 5, 5);
        settle();
        checkOutput("committed value", rd_data_nb[DW-1:0], 32'h1234_5678);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        applyStimulus(2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 5, 5);
        settle();
        checkOutput("reset mid-write data", rd_data_bp[DW-1:0], 32'h0000_0000);
        checkOutput("reset mid-write busy", {31'b0, rd_busy_bp[0]}, 32'h0);
        checkOutput("reset mid-write any", {31'b0, any_busy_bp}, 32'h0);
        nextCycle();

        // Two ports write the same address; port 1 must win.
        applyStimulus(2'b11, 7, 7, 32'h1111_1111, 32'h2222_2222, 2'b00, 0, 0, 7, 7);
        settle();
        checkOutput("conflict bypass", rd_data_bp[DW-1:0], 32'h2222_2222);
        checkOutput("conflict no bypass old", rd_data_nb[DW-1:0], 32'h0000_0000);
        nextCycle();
        applyStimulus(2'b01, 0, 0, 32'hFFFF_FFFF, 0, 2'b00, 0, 0, 0, 7);
        settle();
        checkOutput("conflict stored", rd_data_nb[2*DW-1:DW], 32'h2222_2222);
        checkOutput("zero reg bypass", rd_data_bp[DW-1:0], 32'h0000_0000);
        nextCycle();
        applyStimulus(2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        settle();
        checkOutput("zero reg stored", rd_data_nb[DW-1:0], 32'h0000_0000);
        nextCycle();

        applyStimulus(2'b10, 0, 3, 0, 32'hA5A5_A5A5, 2'b00, 0, 0, 3, 3);
        settle();
        checkOutput("bypass same cycle", rd_data_bp[DW-1:0], 32'hA5A5_A5A5);
        checkOutput("no bypass old value", rd_data_nb[DW-1:0], 32'h0000_0000);
        nextCycle();
        applyStimulus(2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 3, 3);
        settle();
        checkOutput("no bypass next cycle", rd_data_nb[DW-1:0], 32'hA5A5_A5A5);
        nextCycle();

        // Scoreboard: reserve, observe, write back, release.
        applyStimulus(2'b00, 0, 0, 0, 0, 2'b01, 9, 0, 0, 9);
        settle();
        checkOutput("reserve not visible yet", {31'b0, rd_busy_bp[1]}, 32'h0);
        nextCycle();
        applyStimulus(2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 9);
        settle();
        checkOutput("reserved busy", {31'b0, rd_busy_bp[1]}, 32'h1);
        checkOutput("reserved any", {31'b0, any_busy_bp}, 32'h1);
        nextCycle();
        applyStimulus(2'b01, 9, 0, 32'h0000_0099, 0, 2'b00, 0, 0, 0, 9);
        settle();
        checkOutput("writeback busy bypass", {31'b0, rd_busy_bp[1]}, 32'h0);
        checkOutput("writeback busy no bypass", {31'b0, rd_busy_nb[1]}, 32'h1);
        nextCycle();
        applyStimulus(2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 9);
        settle();
        checkOutput("released busy", {31'b0, rd_busy_nb[1]}, 32'h0);
        checkOutput("released any", {31'b0, any_busy_bp}, 32'h0);
        nextCycle();

        applyStimulus(2'b01, 12, 0, 32'h0000_000C, 0, 2'b10, 0, 12, 12, 12);
        nextCycle();
        applyStimulus(2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 12, 12);
        settle();
        checkOutput("reserve beats writeback", {31'b0, rd_busy_bp[0]}, 32'h1);
        checkOutput("reserve beats writeback any", {31'b0, any_busy_bp}, 32'h1);
        nextCycle();
        applyStimulus(2'b01, 12, 0, 32'h0000_000D, 0, 2'b01, 0, 0, 0, 12);
        nextCycle();
        applyStimulus(2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 12);
        settle();
        checkOutput("reg0 never busy", {31'b0, rd_busy_nb[0]}, 32'h0);
        checkOutput("reg12 cleared", {31'b0, rd_busy_nb[1]}, 32'h0);
        checkOutput("all idle any", {31'b0, any_busy_nb}, 32'h0);
        nextCycle();

        // Mixed traffic on a narrow address window to force collisions.
        for (int n = 0; n < 10000; n++) begin
            applyStimulus(WP'($urandom_range(0, 3)), rand_addr(), rand_addr(), $urandom, $urandom,
                          WP'($urandom_range(0, 3)), rand_addr(), rand_addr(), rand_addr(), rand_addr());
            nextCycle();
        end

        applyStimulus(2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        settle();
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
